// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and memory geometry defaults for the unified-memory arbiter.
// The memory instance uses the same width defaults.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant. The grant is combinational; last_grant advances on update.
// On a tie the port that did not win last time is chosen; a lone requester always wins.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant,
  output logic any_req
);

  logic last_grant;

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) grant = ~last_grant;
    else              grant = req1;
  end

  // Resets to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (update) last_grant <= grant;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between instruction fetch (port 0) and load/store (port 1).
// Ack pulses 2+WAIT_CYCLES cycles after the request edge; a requester holds req until its ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       gnt;
  logic       gnt_q;
  logic       we_q;
  logic       any_req;
  logic       start;
  logic       sel_we;

  assign start  = (state == IDLE) && any_req;
  assign sel_we = gnt ? we1 : we0;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .update  (start),
    .grant   (gnt),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            gnt_q     <= gnt;
            we_q      <= sel_we;
            mem_addr  <= gnt ? addr1 : addr0;
            mem_wdata <= gnt ? wdata1 : wdata0;
            wait_cnt  <= WAIT_INIT;
            mem_read  <= ~sel_we;
            mem_write <= sel_we && (WAIT_INIT == 4'd0);
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state     <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ack0      <= ~gnt_q;
            ack1      <= gnt_q;
            if (!we_q) rdata <= mem_rdata;
          end else begin
            wait_cnt  <= wait_cnt - 4'd1;
            // Write strobe only in the last access cycle: exactly one memory write edge.
            mem_write <= we_q && (wait_cnt == 4'd1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
